// File: rtl/grayscale_to_rgb565.sv
//==============================================================================
//  grayscale_to_rgb565
//------------------------------------------------------------------------------
//  Maps a 12-bit grayscale pixel stream to RGB565 using a selectable colour
//  map. The module tracks raster coordinates to tag each output pixel with
//  start-of-frame and end-of-line flags. It is a fixed two-stage pipeline with
//  no backpressure, and it accepts every valid_in cycle.
//
//  Parameters
//    IMG_WIDTH   pixels per line   (2..4096)
//    IMG_HEIGHT  lines per frame   (2..4096)
//    THRESH      gray level at or above which a pixel counts as a hit
//
//  Ports
//    clk         in   1   rising-edge clock
//    aresetn     in   1   asynchronous active-low reset
//    GRAYSCALE   in  12   pixel intensity
//    valid_in    in   1   GRAYSCALE valid this cycle
//    frame_sync  in   1   restart coordinates at (0,0)
//    mode        in   2   00 replicate, 01 binary, 10 marker, 11 invert
//    RED         out  5   red channel
//    GREEN       out  6   green channel
//    BLUE        out  5   blue channel
//    valid_out   out  1   RGB outputs carry a new pixel
//    sof_out     out  1   output pixel is (0,0)
//    eol_out     out  1   output pixel is the last of its line
//
//  Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module grayscale_to_rgb565 #(
  parameter int          IMG_WIDTH  = 640,
  parameter int          IMG_HEIGHT = 480,
  parameter logic [11:0] THRESH     = 12'd2048
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [11:0] GRAYSCALE,
  input  logic        valid_in,
  input  logic        frame_sync,
  input  logic [1:0]  mode,
  output logic [4:0]  RED,
  output logic [5:0]  GREEN,
  output logic [4:0]  BLUE,
  output logic        valid_out,
  output logic        sof_out,
  output logic        eol_out
);

  // Both dimensions top out at 4096, so 12-bit coordinates always suffice.
  localparam logic [11:0] X_MAX = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] Y_MAX = 12'(IMG_HEIGHT - 1);

  localparam logic [1:0] MODE_REPLICATE = 2'b00;
  localparam logic [1:0] MODE_BINARY    = 2'b01;
  localparam logic [1:0] MODE_MARKER    = 2'b10;
  localparam logic [1:0] MODE_INVERT    = 2'b11;

  //--------------------------------------------------------------------------
  // Raster coordinate tracking
  //--------------------------------------------------------------------------
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        pix_sof;
  logic        pix_eol;

  always_comb begin
    // A frame_sync that arrives with a pixel makes that pixel (0,0).
    pix_x   = frame_sync ? 12'd0 : x_q;
    pix_y   = frame_sync ? 12'd0 : y_q;
    pix_sof = (pix_x == 12'd0) && (pix_y == 12'd0);
    pix_eol = (pix_x == X_MAX);

    x_d = x_q;
    y_d = y_q;
    if (valid_in) begin
      if (pix_x == X_MAX) begin
        x_d = 12'd0;
        y_d = (pix_y == Y_MAX) ? 12'd0 : pix_y + 12'd1;
      end else begin
        x_d = pix_x + 12'd1;
        y_d = pix_y;
      end
    end else if (frame_sync) begin
      x_d = 12'd0;
      y_d = 12'd0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      x_q <= 12'd0;
      y_q <= 12'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  //--------------------------------------------------------------------------
  // Stage 1: capture pixel, its mode, hit flag and raster flags
  //--------------------------------------------------------------------------
  logic [11:0] gray_q;
  logic [1:0]  mode_q;
  logic        hit_q;
  logic        sof1_q;
  logic        eol1_q;
  logic        valid1_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      gray_q   <= 12'd0;
      mode_q   <= 2'b00;
      hit_q    <= 1'b0;
      sof1_q   <= 1'b0;
      eol1_q   <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      valid1_q <= valid_in;
      if (valid_in) begin
        gray_q <= GRAYSCALE;
        mode_q <= mode;
        hit_q  <= (GRAYSCALE >= THRESH);
        sof1_q <= pix_sof;
        eol1_q <= pix_eol;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Stage 2: colour mapping
  //--------------------------------------------------------------------------
  logic [11:0] src;
  logic [4:0]  red_d;
  logic [5:0]  green_d;
  logic [4:0]  blue_d;
  logic [4:0]  red_q;
  logic [5:0]  green_q;
  logic [4:0]  blue_q;
  logic        sof_q;
  logic        eol_q;
  logic        valid2_q;

  // The six least-significant bits never reach a 565 channel.
  logic        unused_src_lsbs;
  assign unused_src_lsbs = ^src[5:0];

  always_comb begin
    // 4095 - g cannot underflow for a 12-bit g.
    src     = (mode_q == MODE_INVERT) ? (12'hFFF - gray_q) : gray_q;
    red_d   = src[11:7];
    green_d = src[11:6];
    blue_d  = src[11:7];
    case (mode_q)
      MODE_BINARY: begin
        red_d   = hit_q ? 5'd31 : 5'd0;
        green_d = hit_q ? 6'd63 : 6'd0;
        blue_d  = hit_q ? 5'd31 : 5'd0;
      end
      MODE_MARKER: begin
        if (hit_q) begin
          red_d   = 5'd31;
          green_d = 6'd0;
          blue_d  = 5'd0;
        end
      end
      MODE_REPLICATE, MODE_INVERT: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      red_q    <= 5'd0;
      green_q  <= 6'd0;
      blue_q   <= 5'd0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      valid2_q <= valid1_q;
      if (valid1_q) begin
        red_q   <= red_d;
        green_q <= green_d;
        blue_q  <= blue_d;
        sof_q   <= sof1_q;
        eol_q   <= eol1_q;
      end
    end
  end

  assign RED       = red_q;
  assign GREEN     = green_q;
  assign BLUE      = blue_q;
  assign sof_out   = sof_q;
  assign eol_out   = eol_q;
  assign valid_out = valid2_q;

endmodule

`default_nettype wire

// File: tb/tb_grayscale_to_rgb565.sv
//==============================================================================
//  tb_grayscale_to_rgb565
//------------------------------------------------------------------------------
//  Self-checking bench for grayscale_to_rgb565 with a 4x2 image.
//
//  Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module tb_grayscale_to_rgb565;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk        = 1'b0;
  logic        aresetn    = 1'b0;
  logic [11:0] GRAYSCALE  = 12'd0;
  logic        valid_in   = 1'b0;
  logic        frame_sync = 1'b0;
  logic [1:0]  mode       = 2'b00;
  logic [4:0]  RED;
  logic [5:0]  GREEN;
  logic [4:0]  BLUE;
  logic        valid_out;
  logic        sof_out;
  logic        eol_out;

  always #5 clk = ~clk;

  grayscale_to_rgb565 #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .THRESH    (12'd2048)
  ) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .GRAYSCALE (GRAYSCALE),
    .valid_in  (valid_in),
    .frame_sync(frame_sync),
    .mode      (mode),
    .RED       (RED),
    .GREEN     (GREEN),
    .BLUE      (BLUE),
    .valid_out (valid_out),
    .sof_out   (sof_out),
    .eol_out   (eol_out)
  );

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic       sof;
    logic       eol;
  } exp_t;

  typedef struct {
    logic [11:0] gray;
    logic [1:0]  m;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
  } vec_t;

  vec_t vt [9];
  exp_t sb [$];
  exp_t last  = '0;
  exp_t mon_e;
  bit   obs_sof [$];
  bit   obs_eol [$];
  int   errors = 0;
  int   checks = 0;
  int   mx = 0;
  int   my = 0;
  logic ev1, ev2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference colour map written from the mode definitions.
  function automatic exp_t model(input logic [11:0] g, input logic [1:0] m,
                                 input logic s, input logic e);
    exp_t        x;
    logic [11:0] v;
    logic        hit;
    hit = (g >= 12'd2048);
    v   = (m == 2'b11) ? (12'd4095 - g) : g;
    x.r = v[11:7];
    x.g = v[11:6];
    x.b = v[11:7];
    if (m == 2'b01) begin
      x.r = hit ? 5'd31 : 5'd0;
      x.g = hit ? 6'd63 : 6'd0;
      x.b = hit ? 5'd31 : 5'd0;
    end
    if (m == 2'b10 && hit) begin
      x.r = 5'd31;
      x.g = 6'd0;
      x.b = 5'd0;
    end
    x.sof = s;
    x.eol = e;
    return x;
  endfunction

  // Drives one cycle of inputs from a falling edge and pushes the expected
  // output; use_t substitutes a table colour for the model colour.
  task automatic drive(input logic v, input logic fs, input logic [11:0] g,
                       input logic [1:0] m, input logic use_t, input logic [15:0] trgb);
    int   px, py;
    exp_t e;
    valid_in   = v;
    frame_sync = fs;
    GRAYSCALE  = g;
    mode       = m;
    if (v) begin
      px = fs ? 0 : mx;
      py = fs ? 0 : my;
      e  = model(g, m, (px == 0) && (py == 0), px == W - 1);
      if (use_t) {e.r, e.g, e.b} = trgb;
      sb.push_back(e);
      if (px == W - 1) begin
        mx = 0;
        my = (py == H - 1) ? 0 : py + 1;
      end else begin
        mx = px + 1;
        my = py;
      end
    end else if (fs) begin
      mx = 0;
      my = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 12'd0, 2'b00, 1'b0, 16'd0);
  endtask

  // valid_out is valid_in delayed by two edges.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ev1 <= 1'b0;
      ev2 <= 1'b0;
    end else begin
      ev1 <= valid_in;
      ev2 <= ev1;
    end
  end

  always @(negedge clk) begin
    if (aresetn) begin
      chk("valid_out", valid_out, ev2);
      if (valid_out) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got valid_out=1 expected no pixel at %0t", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("RED", RED, mon_e.r);
          chk("GREEN", GREEN, mon_e.g);
          chk("BLUE", BLUE, mon_e.b);
          chk("sof_out", sof_out, mon_e.sof);
          chk("eol_out", eol_out, mon_e.eol);
          last = mon_e;
          obs_sof.push_back(sof_out);
          obs_eol.push_back(eol_out);
        end
      end else begin
        chk("hold_outputs", {RED, GREEN, BLUE, sof_out, eol_out}, last);
      end
    end
  end

  initial begin
    logic [8:0] sofv, eolv;
    logic [4:0] sof5, eol5;

    vt[0] = '{12'd2500, 2'b00, 5'd19, 6'd39, 5'd19};
    vt[1] = '{12'd2500, 2'b11, 5'd12, 6'd24, 5'd12};
    vt[2] = '{12'd2500, 2'b01, 5'd31, 6'd63, 5'd31};
    vt[3] = '{12'd2500, 2'b10, 5'd31, 6'd0,  5'd0 };
    vt[4] = '{12'd2047, 2'b10, 5'd15, 6'd31, 5'd15};
    vt[5] = '{12'd2047, 2'b01, 5'd0,  6'd0,  5'd0 };
    vt[6] = '{12'd2048, 2'b01, 5'd31, 6'd63, 5'd31};
    vt[7] = '{12'd0,    2'b11, 5'd31, 6'd63, 5'd31};
    vt[8] = '{12'd4095, 2'b00, 5'd31, 6'd63, 5'd31};

    // Reset state
    #3;
    chk("reset_outputs", {RED, GREEN, BLUE, valid_out, sof_out, eol_out}, 32'd0);
    @(negedge clk);
    #2 aresetn = 1'b1;
    @(negedge clk);

    // Table vectors, back to back with a mode change on every pixel
    for (int i = 0; i < 9; i++)
      drive(1'b1, 1'b0, vt[i].gray, vt[i].m, 1'b1, {vt[i].r, vt[i].g, vt[i].b});
    idle(3);

    // 9 continuous pixels through a 4x2 frame
    drive(1'b0, 1'b1, 12'd0, 2'b00, 1'b0, 16'd0);
    obs_sof.delete();
    obs_eol.delete();
    for (int i = 0; i < 9; i++)
      drive(1'b1, 1'b0, 12'(i * 450), 2'(i % 4), 1'b0, 16'd0);
    idle(3);
    chk("frame_pixel_count", obs_sof.size(), 9);
    sofv = '0;
    eolv = '0;
    for (int i = 0; i < 9 && i < obs_sof.size(); i++) begin
      sofv[i] = obs_sof[i];
      eolv[i] = obs_eol[i];
    end
    chk("sof_pattern", sofv, 9'b1_0000_0001);
    chk("eol_pattern", eolv, 9'b0_1000_1000);

    // valid_in 1,0,1 with output hold through the gap
    obs_sof.delete();
    drive(1'b1, 1'b0, 12'd3000, 2'b00, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 12'd77,   2'b01, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 12'd1000, 2'b00, 1'b0, 16'd0);
    idle(3);
    chk("gap_pixel_count", obs_sof.size(), 2);

    // Reset in the middle of a frame after five pixels
    drive(1'b0, 1'b1, 12'd0, 2'b00, 1'b0, 16'd0);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b0, 12'(600 + i * 500), 2'b00, 1'b0, 16'd0);
    valid_in = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("async_reset_outputs", {RED, GREEN, BLUE, valid_out, sof_out, eol_out}, 32'd0);
    sb.delete();
    mx   = 0;
    my   = 0;
    last = '0;
    @(negedge clk);
    #2 aresetn = 1'b1;
    @(negedge clk);

    // Three pixels, then frame_sync with a pixel, then one more pixel
    obs_sof.delete();
    obs_eol.delete();
    drive(1'b1, 1'b0, 12'd2500, 2'b00, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 12'd100,  2'b11, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 12'd3000, 2'b10, 1'b0, 16'd0);
    drive(1'b1, 1'b1, 12'd1234, 2'b00, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 12'd4000, 2'b01, 1'b0, 16'd0);
    idle(3);
    chk("post_reset_count", obs_sof.size(), 5);
    sof5 = '0;
    eol5 = '0;
    for (int i = 0; i < 5 && i < obs_sof.size(); i++) begin
      sof5[i] = obs_sof[i];
      eol5[i] = obs_eol[i];
    end
    chk("post_reset_sof_pattern", sof5, 5'b01001);
    chk("post_reset_eol_pattern", eol5, 5'b00000);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/grayscale_to_rgb565.md
GRAYSCALE_TO_RGB565 -- requirements
Module: grayscale_to_rgb565

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line; the legal range is 2..4096.
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame; the legal range is 2..4096.
REQ-003 Parameter THRESH, default 12'd2048, gray level at or above which a pixel is "hit".
REQ-004 Ports SHALL be exactly as listed below:
- clk  in  1  single clock, rising edge.
- aresetn  in  1  reset; asynchronous, active-low.
- GRAYSCALE  in  12  pixel intensity.
- valid_in  in  1  GRAYSCALE is valid this cycle.
- frame_sync  in  1  restart pixel coordinates at (0,0).
- mode  in  2  colour mapping select.
- RED  out  5  red channel.
- GREEN  out  6  green channel.
- BLUE  out  5  blue channel.
- valid_out  out  1  RGB outputs carry a new pixel.
- sof_out  out  1  output pixel is (0,0).
- eol_out  out  1  output pixel is last of its line.

Function
REQ-005 The datapath SHALL be a two-stage register pipeline with no backpressure; every valid_in=1 cycle is accepted.
REQ-006 Stage 1 SHALL register GRAYSCALE, mode, the hit flag (GRAYSCALE >= THRESH), and the current x/y-derived sof/eol flags; these registers load only when valid_in=1.
REQ-007 Stage 1 SHALL set its valid register to valid_in every cycle.
REQ-008 Stage 2 SHALL compute RGB from the stage-1 registers and load RED/GREEN/BLUE/sof_out/eol_out only when stage-1 valid=1; otherwise these outputs hold their values.
REQ-009 valid_out SHALL equal stage-1 valid delayed one cycle; a pixel sampled at edge k appears with valid_out=1 after edge k+1 (latency 2 edges).
REQ-010 Mode 00, replicate: R=g[11:7], G=g[11:6], B=g[11:7].
REQ-011 Mode 01, binary: hit gives R=31,G=63,B=31; otherwise all zero.
REQ-012 Mode 10, marker: hit gives R=31,G=0,B=0; otherwise replicate as in mode 00.
REQ-013 Mode 11, invert: replicate applied to (4095 - g), computed in 12 bits with no overflow possible.
REQ-014 mode SHALL be sampled per pixel with that pixel's GRAYSCALE; a mode change mid-stream affects only later pixels.
REQ-015 Counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) SHALL describe the coordinate of the next accepted pixel.
REQ-016 On each valid_in=1 with frame_sync=0, x increments. At x=IMG_WIDTH-1, x wraps to 0 and y increments. At y=IMG_HEIGHT-1 with x at max, both wrap to 0.
REQ-017 The sof flag for a pixel SHALL be (x==0 && y==0); the eol flag SHALL be (x==IMG_WIDTH-1).
REQ-018 frame_sync=1 with valid_in=0 SHALL set x=0, y=0.
REQ-019 frame_sync=1 with valid_in=1 SHALL treat that pixel as (0,0), with sof=1, and leave x=1, y=0 afterward.
REQ-020 Counters and pipeline SHALL not change on valid_in=0 cycles, except frame_sync per REQ-018.

Reset
REQ-021 Asserting aresetn=0 SHALL immediately clear all outputs, pipeline registers and x/y counters to 0, regardless of clk.
REQ-022 Reset mid-frame SHALL discard in-flight pixels; the first pixel after release is (0,0) with sof_out=1.
REQ-023 Deassertion is sampled on clk; the first valid_in may coincide with the first edge after release.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Mode 00, GRAYSCALE=2500 held with valid_in=1 -> after 2 edges RED=19, GREEN=39, BLUE=19, valid_out=1.
- Mode 11, GRAYSCALE=2500 -> RED=12, GREEN=24, BLUE=12.
- THRESH=2048, GRAYSCALE=2500: mode 01 -> 31/63/31; mode 10 -> 31/0/0; GRAYSCALE=2047 in mode 10 -> 15/31/15.
- IMG_WIDTH=4, IMG_HEIGHT=2, 9 continuous pixels:
  - sof_out on pixels 0 and 8.
  - eol_out on pixels 3 and 7.
- valid_in toggling 1,0,1 -> valid_out 1,0,1 delayed 2 edges; RGB holds during the gap.
- Reset after pixel 5 of a frame, then frame_sync+valid_in together on a later frame:
  - aresetn pulse -> outputs 0 immediately; next pixel has sof_out=1.
  - frame_sync pixel -> sof_out=1.
